// File: rtl/adc_block_averager.sv
// Block averager for the AD4008 sample stream: mean, min and max over blocks of 2**LOG2_N
// samples, presented on a one-entry valid/ready output with a sticky overrun flag.
module adc_block_averager #(
  parameter int ADC_WIDTH = 16,
  parameter int LOG2_N    = 2
) (
  input  logic                 clk,
  input  logic                 sreset,
  input  logic                 enable,
  input  logic [ADC_WIDTH-1:0] sample_in,
  input  logic                 sample_valid,
  output logic [ADC_WIDTH-1:0] avg_data,
  output logic [ADC_WIDTH-1:0] min_data,
  output logic [ADC_WIDTH-1:0] max_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LOG2_N-1:0]    fill_count,
  output logic                 overrun,
  input  logic                 clr_overrun
);

  localparam int ACC_W = ADC_WIDTH + LOG2_N;
  localparam logic [LOG2_N-1:0] FILL_LAST = {LOG2_N{1'b1}};

  typedef enum logic {ACCUM, LAST} state_t;

  state_t                 state_q, state_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [ADC_WIDTH-1:0]   minTrk_q, minTrk_d;
  logic [ADC_WIDTH-1:0]   maxTrk_q, maxTrk_d;
  logic [LOG2_N-1:0]      fill_q, fill_d;
  logic [ADC_WIDTH-1:0]   avg_q, avg_d;
  logic [ADC_WIDTH-1:0]   minOut_q, minOut_d;
  logic [ADC_WIDTH-1:0]   maxOut_q, maxOut_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;

  logic                   take;
  logic                   restart;
  logic                   commit;
  logic [ACC_W-1:0]       accShift;
  logic [ACC_W-1:0]       baseAcc;
  logic [ADC_WIDTH-1:0]   baseMin;
  logic [ADC_WIDTH-1:0]   baseMax;
  logic [LOG2_N-1:0]      baseFill;

  assign take     = enable && sample_valid;
  assign restart  = (state_q == LAST) || !enable;
  assign accShift = acc_q >> LOG2_N;

  always_ff @(posedge clk) begin
    if (sreset) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = ACCUM;
    if (state_q == ACCUM && take && fill_q == FILL_LAST) state_d = LAST;
  end

  // LAST starts a fresh block from empty trackers, so a sample arriving there becomes sample 0.
  always_comb begin
    baseAcc  = restart ? '0 : acc_q;
    baseMin  = restart ? '1 : minTrk_q;
    baseMax  = restart ? '0 : maxTrk_q;
    baseFill = restart ? '0 : fill_q;
    acc_d    = baseAcc;
    minTrk_d = baseMin;
    maxTrk_d = baseMax;
    fill_d   = baseFill;
    if (take) begin
      acc_d    = baseAcc + {{LOG2_N{1'b0}}, sample_in};
      minTrk_d = (sample_in < baseMin) ? sample_in : baseMin;
      maxTrk_d = (sample_in > baseMax) ? sample_in : baseMax;
      fill_d   = baseFill + 1'b1;
    end
  end

  always_comb begin
    commit    = (state_q == LAST) && (!valid_q || out_ready);
    avg_d     = avg_q;
    minOut_d  = minOut_q;
    maxOut_d  = maxOut_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (commit) begin
      avg_d    = accShift[ADC_WIDTH-1:0];
      minOut_d = minTrk_q;
      maxOut_d = maxTrk_q;
      valid_d  = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (state_q == LAST && valid_q && !out_ready) overrun_d = 1'b1;
    else if (clr_overrun)                         overrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      acc_q     <= '0;
      minTrk_q  <= '1;
      maxTrk_q  <= '0;
      fill_q    <= '0;
      avg_q     <= '0;
      minOut_q  <= '0;
      maxOut_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      minTrk_q  <= minTrk_d;
      maxTrk_q  <= maxTrk_d;
      fill_q    <= fill_d;
      avg_q     <= avg_d;
      minOut_q  <= minOut_d;
      maxOut_q  <= maxOut_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign avg_data   = avg_q;
  assign min_data   = minOut_q;
  assign max_data   = maxOut_q;
  assign out_valid  = valid_q;
  assign fill_count = fill_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_adc_block_averager.sv
// Self-checking bench for adc_block_averager: sample-list reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_adc_block_averager;

  localparam int ADC_WIDTH = 16;
  localparam int LOG2_N    = 2;
  localparam int N         = 1 << LOG2_N;

  logic                 clk = 1'b0;
  logic                 sreset = 1'b1;
  logic                 enable = 1'b0;
  logic [ADC_WIDTH-1:0] sample_in = '0;
  logic                 sample_valid = 1'b0;
  logic [ADC_WIDTH-1:0] avg_data, min_data, max_data;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [LOG2_N-1:0]    fill_count;
  logic                 overrun;
  logic                 clr_overrun = 1'b0;

  int errors = 0;
  int checks = 0;

  adc_block_averager #(.ADC_WIDTH(ADC_WIDTH), .LOG2_N(LOG2_N)) dut (
    .clk(clk), .sreset(sreset), .enable(enable), .sample_in(sample_in),
    .sample_valid(sample_valid), .avg_data(avg_data), .min_data(min_data),
    .max_data(max_data), .out_valid(out_valid), .out_ready(out_ready),
    .fill_count(fill_count), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  // Reference model: the current block is a plain list of samples; a completed block's
  // result is offered for commit on the following cycle.
  int  blk[$];
  bit  started = 0;
  bit  pendReady = 0;
  int  pendAvg, pendMin, pendMax;
  bit  expValid = 0;
  int  expAvg = 0, expMin = 0, expMax = 0, expFill = 0;
  bit  expOverrun = 0;
  bit  setOv;
  longint sum;

  always @(posedge clk) begin
    if (sreset) begin
      blk.delete();
      pendReady = 0;
      expValid = 0; expAvg = 0; expMin = 0; expMax = 0; expFill = 0; expOverrun = 0;
      started = 1;
    end else begin
      setOv = 0;
      if (pendReady) begin
        if (!expValid || out_ready) begin
          expAvg = pendAvg; expMin = pendMin; expMax = pendMax; expValid = 1;
        end else setOv = 1;
      end else if (expValid && out_ready) expValid = 0;
      if (setOv) expOverrun = 1;
      else if (clr_overrun) expOverrun = 0;
      pendReady = 0;
      if (!enable) blk.delete();
      else if (sample_valid) begin
        blk.push_back(int'(sample_in));
        if (blk.size() == N) begin
          sum = 0; pendMin = blk[0]; pendMax = blk[0];
          foreach (blk[k]) begin
            sum += blk[k];
            if (blk[k] < pendMin) pendMin = blk[k];
            if (blk[k] > pendMax) pendMax = blk[k];
          end
          pendAvg = int'(sum / N);
          pendReady = 1;
          blk.delete();
        end
      end
      expFill = blk.size();
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      checkOutput("model.out_valid", out_valid, expValid);
      checkOutput("model.avg", avg_data, expAvg);
      checkOutput("model.min", min_data, expMin);
      checkOutput("model.max", max_data, expMax);
      checkOutput("model.fill", fill_count, expFill);
      checkOutput("model.overrun", overrun, expOverrun);
    end
  end

  task automatic applyStimulus(input logic en, input logic v, input logic [ADC_WIDTH-1:0] s,
                               input logic rdy, input logic clr, input logic rst);
    enable = en; sample_valid = v; sample_in = s;
    out_ready = rdy; clr_overrun = clr; sreset = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic sendBlock(input int a, input int b, input int c, input int d, input logic rdy);
    applyStimulus(1, 1, 16'(a), rdy, 0, 0);
    applyStimulus(1, 1, 16'(b), rdy, 0, 0);
    applyStimulus(1, 1, 16'(c), rdy, 0, 0);
    applyStimulus(1, 1, 16'(d), rdy, 0, 0);
  endtask

  initial begin
    int r;
    logic [ADC_WIDTH-1:0] s;
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("reset.valid", out_valid, 0);
    checkOutput("reset.avg", avg_data, 0);
    checkOutput("reset.overrun", overrun, 0);
    checkOutput("reset.fill", fill_count, 0);

    // Basic block with fill_count progression
    applyStimulus(1, 1, 10, 1, 0, 0); checkOutput("t1.fill1", fill_count, 1);
    applyStimulus(1, 1, 20, 1, 0, 0); checkOutput("t1.fill2", fill_count, 2);
    applyStimulus(1, 1, 30, 1, 0, 0); checkOutput("t1.fill3", fill_count, 3);
    applyStimulus(1, 1, 41, 1, 0, 0); checkOutput("t1.fill0", fill_count, 0);
    checkOutput("t1.validEarly", out_valid, 0);
    applyStimulus(1, 0, 0, 1, 0, 0);
    checkOutput("t1.valid", out_valid, 1);
    checkOutput("t1.avg", avg_data, 25);
    checkOutput("t1.min", min_data, 10);
    checkOutput("t1.max", max_data, 41);
    applyStimulus(1, 0, 0, 1, 0, 0);
    checkOutput("t1.validDrop", out_valid, 0);

    // Full-scale samples: no accumulator overflow
    sendBlock(65535, 65535, 65535, 65535, 1);
    applyStimulus(1, 0, 0, 1, 0, 0);
    checkOutput("t2.avgMax", avg_data, 65535);
    checkOutput("t2.minMax", min_data, 65535);
    checkOutput("t2.maxMax", max_data, 65535);
    sendBlock(0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 1, 0, 0);
    checkOutput("t2.avgZero", avg_data, 0);
    checkOutput("t2.maxZero", max_data, 0);
    applyStimulus(1, 0, 0, 1, 0, 0);

    // Backpressure across two blocks
    sendBlock(100, 100, 100, 100, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t3.valid", out_valid, 1);
    sendBlock(200, 200, 200, 200, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t3.overrun", overrun, 1);
    checkOutput("t3.heldAvg", avg_data, 100);
    applyStimulus(1, 0, 0, 1, 0, 0);
    checkOutput("t3.accepted", out_valid, 0);
    checkOutput("t3.overrunSticky", overrun, 1);
    applyStimulus(1, 0, 0, 0, 1, 0);
    checkOutput("t3.overrunClr", overrun, 0);

    // Accept and new result in the same cycle
    sendBlock(50, 50, 50, 50, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t4.avg50", avg_data, 50);
    sendBlock(60, 60, 60, 60, 0);
    applyStimulus(1, 0, 0, 1, 0, 0);
    checkOutput("t4.validKept", out_valid, 1);
    checkOutput("t4.avg60", avg_data, 60);
    checkOutput("t4.noOverrun", overrun, 0);
    applyStimulus(1, 0, 0, 1, 0, 0);

    // enable=0 discards a partial block
    applyStimulus(1, 1, 5, 1, 0, 0);
    applyStimulus(1, 1, 7, 1, 0, 0);
    applyStimulus(0, 1, 9, 1, 0, 0);
    checkOutput("t5.fillCleared", fill_count, 0);
    sendBlock(8, 8, 8, 8, 1);
    applyStimulus(1, 0, 0, 1, 0, 0);
    checkOutput("t5.avg", avg_data, 8);
    checkOutput("t5.min", min_data, 8);
    applyStimulus(1, 0, 0, 1, 0, 0);

    // Reset mid-block with a pending result
    sendBlock(9, 9, 9, 9, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 3, 0, 0, 0);
    applyStimulus(1, 1, 3, 0, 0, 0);
    applyStimulus(1, 1, 3, 0, 0, 1);
    checkOutput("t6.valid", out_valid, 0);
    checkOutput("t6.avg", avg_data, 0);
    checkOutput("t6.fill", fill_count, 0);
    sendBlock(4, 8, 12, 16, 1);
    applyStimulus(1, 0, 0, 1, 0, 0);
    checkOutput("t6.avgNew", avg_data, 10);
    checkOutput("t6.minNew", min_data, 4);
    checkOutput("t6.maxNew", max_data, 16);

    // Randomized soak against the model
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 3);
      s = (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : 16'($urandom);
      applyStimulus(($urandom_range(0, 15) != 0), ($urandom_range(0, 2) != 0), s,
                    ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 299) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
